// File: rtl/jump_lut_loader.sv
// Jump-target table writer: assembles D-bit targets from byte pairs on a
// valid/ready stream, fills entries 0..N-1 in order, and serves registered lookups.

module jump_lut_entry #(
  parameter int           D    = 10,
  parameter logic [D-1:0] INIT = '0
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         we,
  input  logic [D-1:0] wd,
  output logic [D-1:0] q
);
  always_ff @(posedge clk) begin
    if (reset)   q <= INIT;
    else if (we) q <= wd;
  end
endmodule

module jump_lut_loader #(
  parameter  int D  = 10,
  parameter  int N  = 16,
  parameter  int B  = 8,
  localparam int IW = $clog2(N)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          load_start,
  input  logic          in_valid,
  input  logic [B-1:0]  in_data,
  output logic          in_ready,
  output logic          load_busy,
  output logic          load_done,
  output logic          load_err,
  input  logic          rd_en,
  input  logic [IW-1:0] rd_idx,
  output logic [D-1:0]  rd_target,
  output logic          rd_valid
);
  typedef enum logic [1:0] {IDLE, LO, HI, DONE} state_t;

  state_t              state, state_nxt;
  logic [IW-1:0]       cnt;
  logic [B-1:0]        lo_q;
  logic                err_q;
  logic                start_acc, wr_en, last;
  logic [B-1:0]        hi_extra;
  logic [D-1:0]        wr_data;
  logic [N-1:0][D-1:0] tbl;
  logic [1:0]          vld_pipe;

  assign start_acc = (state == IDLE) && load_start;
  assign wr_en     = (state == HI) && in_valid;
  assign last      = (cnt == IW'(N-1));
  // Bits of the high byte that do not fit in the target are flagged, then dropped.
  assign hi_extra  = in_data >> (D-B);
  assign wr_data   = D'({in_data, lo_q});
  assign load_busy = (state != IDLE);
  assign load_err  = err_q;

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    in_ready  = 1'b0;
    load_done = 1'b0;
    case (state)
      IDLE: if (load_start) state_nxt = LO;
      LO: begin
        in_ready = 1'b1;
        if (in_valid) state_nxt = HI;
      end
      HI: begin
        in_ready = 1'b1;
        if (in_valid) state_nxt = last ? DONE : LO;
      end
      DONE: begin
        load_done = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt   <= '0;
      lo_q  <= '0;
      err_q <= 1'b0;
    end else begin
      if (start_acc) begin
        cnt   <= '0;
        err_q <= 1'b0;
      end
      if ((state == LO) && in_valid) lo_q <= in_data;
      if (wr_en) begin
        if (hi_extra != '0) err_q <= 1'b1;
        if (!last)          cnt   <= cnt + 1'b1;
      end
    end
  end

  // Reset defaults are one-hot targets repeating every 10 entries.
  for (genvar i = 0; i < N; i++) begin : g_ent
    localparam logic [D-1:0] INIT = D'(32'd1 << (i % 10));
    jump_lut_entry #(.D(D), .INIT(INIT)) u_ent (
      .clk   (clk),
      .reset (reset),
      .we    (wr_en && (cnt == IW'(i))),
      .wd    (wr_data),
      .q     (tbl[i])
    );
  end

  // Registered read sees pre-write contents on a same-cycle collision.
  assign vld_pipe[0] = rd_en;
  assign rd_valid    = vld_pipe[1];

  always_ff @(posedge clk) begin
    if (reset) begin
      vld_pipe[1] <= 1'b0;
      rd_target   <= '0;
    end else begin
      vld_pipe[1] <= vld_pipe[0];
      if (rd_en) rd_target <= tbl[rd_idx];
    end
  end
endmodule

// File: tb/tb_jump_lut_loader.sv
// Randomized self-checking bench for jump_lut_loader against a table-level model.

module tb_jump_lut_loader;
  localparam int D  = 10;
  localparam int N  = 16;
  localparam int B  = 8;
  localparam int IW = 4;

  logic          clk = 1'b0;
  logic          reset, load_start, in_valid, rd_en;
  logic [B-1:0]  in_data;
  logic [IW-1:0] rd_idx;
  logic          in_ready, load_busy, load_done, load_err, rd_valid;
  logic [D-1:0]  rd_target;

  int            n_checks = 0;
  int            n_fail   = 0;
  logic [D-1:0]  model [N];
  logic [B-1:0]  lo_b [N];
  logic [B-1:0]  hi_b [N];

  always #5 clk = ~clk;

  jump_lut_loader #(.D(D), .N(N), .B(B)) dut (
    .clk        (clk),
    .reset      (reset),
    .load_start (load_start),
    .in_valid   (in_valid),
    .in_data    (in_data),
    .in_ready   (in_ready),
    .load_busy  (load_busy),
    .load_done  (load_done),
    .load_err   (load_err),
    .rd_en      (rd_en),
    .rd_idx     (rd_idx),
    .rd_target  (rd_target),
    .rd_valid   (rd_valid)
  );

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic apply_reset;
    reset = 1'b1; load_start = 1'b0; in_valid = 1'b0; in_data = '0;
    rd_en = 1'b0; rd_idx = '0;
    tick; tick;
    reset = 1'b0;
    for (int i = 0; i < N; i++) model[i] = D'(1 << (i % 10));
  endtask

  function automatic bit expect_err;
    bit e = 1'b0;
    for (int i = 0; i < N; i++) if ((hi_b[i] >> (D-B)) != 0) e = 1'b1;
    return e;
  endfunction

  // Streams entries first..lst; optional one idle cycle after each byte.
  task automatic stream(input int first, input int lst, input bit stall, inout int cycles);
    for (int e = first; e <= lst; e++) begin
      for (int h = 0; h < 2; h++) begin
        n_checks++;
        if (in_ready !== 1'b1) begin
          n_fail++;
          $display("FAIL in_ready_stream e%0d h%0d: got %b want 1", e, h, in_ready);
        end
        in_valid = 1'b1;
        in_data  = h ? hi_b[e] : lo_b[e];
        tick; cycles++;
        in_valid = 1'b0;
        if (h == 1) model[e] = D'((int'(hi_b[e]) << B) | int'(lo_b[e]));
        if (stall && !(e == N-1 && h == 1)) begin tick; cycles++; end
      end
    end
  endtask

  task automatic run_load(input bit stall, output int cycles);
    bit exp_err;
    exp_err = expect_err();
    cycles = 0;
    load_start = 1'b1; tick; load_start = 1'b0;
    n_checks++;
    if (load_busy !== 1'b1 || load_err !== 1'b0) begin
      n_fail++;
      $display("FAIL load_begin: busy=%b err=%b want busy=1 err=0", load_busy, load_err);
    end
    stream(0, N-1, stall, cycles);
    n_checks++;
    if (load_done !== 1'b1 || in_ready !== 1'b0 || load_busy !== 1'b1 || load_err !== exp_err) begin
      n_fail++;
      $display("FAIL load_done_pulse: done=%b ready=%b busy=%b err=%b want 1 0 1 %b",
               load_done, in_ready, load_busy, load_err, exp_err);
    end
    tick;
    n_checks++;
    if (load_done !== 1'b0 || load_busy !== 1'b0 || load_err !== exp_err) begin
      n_fail++;
      $display("FAIL load_done_end: done=%b busy=%b err=%b want 0 0 %b",
               load_done, load_busy, load_err, exp_err);
    end
  endtask

  task automatic read_all(input string tag);
    for (int i = 0; i < N; i++) begin
      rd_en = 1'b1; rd_idx = IW'(i);
      tick;
      rd_en = 1'b0;
      n_checks++;
      if (rd_valid !== 1'b1 || rd_target !== model[i]) begin
        n_fail++;
        $display("FAIL %s idx%0d: got v=%b t=%h want v=1 t=%h", tag, i, rd_valid, rd_target, model[i]);
      end
    end
  endtask

  task automatic test_reset;
    logic [D-1:0] exp_t [4];
    int           idx   [4];
    apply_reset;
    n_checks++;
    if (in_ready !== 0 || load_busy !== 0 || load_done !== 0 || load_err !== 0 ||
        rd_valid !== 0 || rd_target !== '0) begin
      n_fail++;
      $display("FAIL reset_outputs: rdy=%b busy=%b done=%b err=%b rv=%b rt=%h want all 0",
               in_ready, load_busy, load_done, load_err, rd_valid, rd_target);
    end
    idx = '{0, 3, 9, 15};
    exp_t = '{10'h001, 10'h008, 10'h200, 10'h020};
    for (int k = 0; k < 4; k++) begin
      rd_en = 1'b1; rd_idx = IW'(idx[k]);
      tick;
      rd_en = 1'b0;
      n_checks++;
      if (rd_valid !== 1'b1 || rd_target !== exp_t[k]) begin
        n_fail++;
        $display("FAIL reset_default idx%0d: got v=%b t=%h want v=1 t=%h", idx[k], rd_valid, rd_target, exp_t[k]);
      end
    end
    tick;
    n_checks++;
    if (rd_valid !== 1'b0 || rd_target !== 10'h020) begin
      n_fail++;
      $display("FAIL rd_valid_drop: got v=%b t=%h want v=0 t=020", rd_valid, rd_target);
    end
  endtask

  task automatic test_load;
    int cyc;
    for (int i = 0; i < N; i++) begin lo_b[i] = B'(i); hi_b[i] = 8'h01; end
    in_valid = 1'b1; in_data = 8'hAA;
    for (int k = 0; k < 3; k++) begin
      tick;
      n_checks++;
      if (in_ready !== 1'b0 || load_busy !== 1'b0) begin
        n_fail++;
        $display("FAIL idle_no_accept: ready=%b busy=%b want 0 0", in_ready, load_busy);
      end
    end
    in_valid = 1'b0;
    run_load(1'b0, cyc);
    n_checks++;
    if (cyc !== 32) begin
      n_fail++;
      $display("FAIL load_cycles: got %0d want 32", cyc);
    end
    rd_en = 1'b1; rd_idx = 4'd7; tick; rd_en = 1'b0;
    n_checks++;
    if (rd_target !== 10'h107) begin
      n_fail++;
      $display("FAIL load_idx7: got %h want 107", rd_target);
    end
    read_all("load_table");
  endtask

  task automatic test_stall;
    int cyc;
    apply_reset;
    run_load(1'b1, cyc);
    n_checks++;
    if (cyc !== 63) begin
      n_fail++;
      $display("FAIL stall_cycles: got %0d want 63", cyc);
    end
    read_all("stall_table");
  endtask

  task automatic test_err;
    int cyc;
    for (int i = 0; i < N; i++) begin
      lo_b[i] = B'($urandom_range(0, 255));
      hi_b[i] = B'($urandom_range(0, 3));
    end
    hi_b[2] = 8'hFD;
    run_load(1'b0, cyc);
    tick; tick; tick;
    n_checks++;
    if (load_err !== 1'b1) begin
      n_fail++;
      $display("FAIL err_sticky: got %b want 1", load_err);
    end
    rd_en = 1'b1; rd_idx = 4'd2; tick; rd_en = 1'b0;
    n_checks++;
    if (rd_target !== {2'b01, lo_b[2]}) begin
      n_fail++;
      $display("FAIL err_entry2: got %h want %h", rd_target, {2'b01, lo_b[2]});
    end
    load_start = 1'b1; tick; load_start = 1'b0;
    n_checks++;
    if (load_err !== 1'b0 || load_busy !== 1'b1) begin
      n_fail++;
      $display("FAIL err_clear: err=%b busy=%b want 0 1", load_err, load_busy);
    end
    apply_reset;
  endtask

  task automatic test_random;
    int cyc;
    bit stall;
    for (int it = 0; it < 4; it++) begin
      for (int i = 0; i < N; i++) begin
        lo_b[i] = B'($urandom_range(0, 255));
        hi_b[i] = ($urandom_range(0, 9) == 0) ? B'($urandom_range(0, 255)) : B'($urandom_range(0, 3));
      end
      stall = 1'($urandom_range(0, 1));
      run_load(stall, cyc);
      n_checks++;
      if (cyc !== (stall ? 63 : 32)) begin
        n_fail++;
        $display("FAIL random_cycles it%0d: got %0d want %0d", it, cyc, stall ? 63 : 32);
      end
      read_all("random_table");
    end
  endtask

  task automatic test_collision;
    apply_reset;
    load_start = 1'b1; tick; load_start = 1'b0;
    in_valid = 1'b1; in_data = 8'h55; tick;
    in_data = 8'h01; rd_en = 1'b1; rd_idx = 4'd0; tick;
    in_valid = 1'b0; rd_en = 1'b0;
    n_checks++;
    if (rd_valid !== 1'b1 || rd_target !== 10'h001) begin
      n_fail++;
      $display("FAIL collision_old: got v=%b t=%h want v=1 t=001", rd_valid, rd_target);
    end
    rd_en = 1'b1; rd_idx = 4'd0; tick;
    rd_idx = 4'd1; tick; rd_en = 1'b0;
    n_checks++;
    if (rd_target !== 10'h002) begin
      n_fail++;
      $display("FAIL collision_unwritten: got %h want 002", rd_target);
    end
    n_checks++;
    if (dut.tbl[0] !== 10'h155) begin
      n_fail++;
      $display("FAIL collision_new_entry: got %h want 155", dut.tbl[0]);
    end
    apply_reset;
    load_start = 1'b1; tick; load_start = 1'b0;
    in_valid = 1'b1; in_data = 8'h55; tick;
    in_data = 8'h01; tick;
    in_valid = 1'b0;
    rd_en = 1'b1; rd_idx = 4'd0; tick; rd_en = 1'b0;
    n_checks++;
    if (rd_target !== 10'h155) begin
      n_fail++;
      $display("FAIL collision_next_read: got %h want 155", rd_target);
    end
    apply_reset;
  endtask

  task automatic test_restart_ignored;
    int cyc = 0;
    apply_reset;
    for (int i = 0; i < N; i++) begin
      lo_b[i] = B'($urandom_range(0, 255));
      hi_b[i] = B'($urandom_range(0, 3));
    end
    load_start = 1'b1; tick; load_start = 1'b0;
    stream(0, 1, 1'b0, cyc);
    load_start = 1'b1; tick; load_start = 1'b0;
    n_checks++;
    if (load_busy !== 1'b1 || in_ready !== 1'b1 || load_done !== 1'b0) begin
      n_fail++;
      $display("FAIL restart_ignored: busy=%b ready=%b done=%b want 1 1 0", load_busy, in_ready, load_done);
    end
    stream(2, N-1, 1'b0, cyc);
    n_checks++;
    if (load_done !== 1'b1) begin
      n_fail++;
      $display("FAIL restart_done: got %b want 1", load_done);
    end
    tick;
    read_all("restart_table");
  endtask

  task automatic test_reset_midload;
    int cyc = 0;
    for (int i = 0; i < N; i++) begin lo_b[i] = B'(8'h30 + i); hi_b[i] = 8'h02; end
    load_start = 1'b1; tick; load_start = 1'b0;
    stream(0, 1, 1'b0, cyc);
    in_valid = 1'b1; in_data = 8'hEE; tick; in_valid = 1'b0;
    apply_reset;
    n_checks++;
    if (load_busy !== 1'b0 || in_ready !== 1'b0 || load_done !== 1'b0) begin
      n_fail++;
      $display("FAIL midload_reset: busy=%b ready=%b done=%b want 0 0 0", load_busy, in_ready, load_done);
    end
    rd_en = 1'b1; rd_idx = 4'd0; tick; rd_en = 1'b0;
    n_checks++;
    if (rd_target !== 10'h001) begin
      n_fail++;
      $display("FAIL midload_idx0: got %h want 001", rd_target);
    end
    run_load(1'b0, cyc);
    read_all("after_abort_table");
  endtask

  initial begin
    test_reset;
    test_load;
    test_stall;
    test_err;
    test_random;
    test_collision;
    test_restart_ignored;
    test_reset_midload;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
